seq_mult: RTL and testbench
===========================

# seq_mult

Sequential unsigned shift-and-add multiplier with valid/ready handshakes on its operand input and its product output. It sits downstream of the operand registers: it accepts one operand pair, iterates one multiplier bit per clock, and holds the double-width product until the consumer takes it. It is the iterative counterpart to a combinational array multiplier, trading latency for area.

## Interface
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits; WIDTH >= 2.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer takes the product.
- product  output  2*WIDTH  a*b, unsigned.
- busy  output  1  high while iterating (RUN state).

## Operation
- States: IDLE, RUN, DONE. Registers: acc (2W), mcand (2W, a zero-extended), mplier (W), cnt (clog2(W+1) bits).
- IDLE: in_ready=1. On in_valid, capture: mcand<=a, mplier<=b, acc<=0, cnt<=0; go RUN.
- RUN, each edge: if mplier[0], acc<=acc+mcand (2W-bit add, cannot overflow); mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1. Go DONE when cnt==W-1 (the W-th iteration).
- DONE: out_valid=1, product=acc, stable until handshake. On out_ready, go IDLE.
- in_ready is high only in IDLE; out_valid is high only in DONE. No input is accepted while RUN or DONE; a/b are ignored outside the accept edge.
- out_ready outside DONE is ignored. in_valid during DONE is not accepted, even if out_ready is also high; the next pair is accepted in IDLE on the following cycle.
- Reset: rst high at any edge forces IDLE; acc, mcand, mplier, cnt cleared. An in-progress or pending result is discarded.
- Reset values: in_ready=1, out_valid=0, busy=0, product=0.

## Timing
- Accept edge E0 (IDLE, in_valid=1). RUN occupies edges E1..EW; out_valid is high after EW. Latency from accept edge to out_valid is W cycles (8 at default).
- Minimum handshake period for back-to-back operations is W+2 cycles: W cycles RUN, 1 cycle DONE (out_ready high), 1 cycle IDLE for acceptance.
- product is registered and has no combinational path from inputs. in_ready, out_valid and busy are decoded from state only, with no combinational path from in_valid or out_ready.

## Configuration
- SEQ_MULT_EARLY_DONE_EN defined: RUN also exits to DONE at the edge where the shifted mplier (next value) is zero. Latency = max(1, position of highest set bit of b + 1). b=0 takes 1 cycle and gives product 0.
- Not defined: latency is always exactly W cycles, independent of operands.
- The product value is identical in both builds. Only the out_valid timing changes.

## Test plan
- a=13, b=11, out_ready=1: out_valid rises 8 cycles after the accept edge, product=143, in_ready returns high 1 cycle later. With SEQ_MULT_EARLY_DONE_EN, out_valid rises after 4 cycles.
- a=255, b=255: product=65025. a=0, b=200 gives product 0. a=1, b=128 gives product 128, with 8 cycles in both builds.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises. out_valid and product stay stable and in_ready stays 0. Pulsing in_valid with new operands does not change product.
- Back-to-back: in_valid held high with a stream of 3 pairs (3*4, 7*9, 200*100) and out_ready=1. Products are 12, 63, 20000 in order, with accept edges W+2 cycles apart.
- Reset mid-run: assert rst for 1 cycle at the 3rd RUN edge. Next cycle busy=0, out_valid=0, in_ready=1, product=0. A new pair 6*7 then yields 42 with full latency.
- Simultaneous in_valid and out_ready in DONE: the product is consumed, the new pair is not accepted that edge, and it is accepted on the next IDLE edge.

Source files
------------

// File: rtl/seq_mult.sv
// seq_mult: sequential unsigned shift-and-add multiplier.
// Accepts one operand pair on a valid/ready handshake, retires one multiplier
// bit per clock and holds the 2*WIDTH-bit product until the consumer takes it.
// Optional build macro: SEQ_MULT_EARLY_DONE_EN -- leave RUN as soon as the
// remaining multiplier bits are all zero (product is unchanged, only timing).
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic                 last_iter;

  // The current RUN edge is the final iteration.
`ifdef SEQ_MULT_EARLY_DONE_EN
  // Exit once the shifted multiplier would be zero: no further adds can occur.
  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; in_valid/out_ready only steer the transition.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, shift-and-add while running.
  always_ff @(posedge clk) begin
    // NOTE: the datapath is reset as well because product is visible at the
    // port and must read zero after reset, and a pending result is discarded.
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
          end
        end
        RUN: begin
          // 2W-bit accumulator holds the full product, so this add never wraps.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake and status outputs are decoded from state alone.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign product   = acc;

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed self-checking bench for seq_mult (WIDTH = 8).
// Build with +define+SEQ_MULT_EARLY_DONE_EN to check the early-done timing.
module tb_seq_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;

  seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pick the expected latency for the build under test.
  function automatic int pick_lat(input int full_lat, input int early_lat);
`ifdef SEQ_MULT_EARLY_DONE_EN
    return early_lat;
`else
    return full_lat;
`endif
  endfunction

  task automatic chk_bit(input string name, input logic got, input logic exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Count edges after the accept edge until out_valid shows, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  // Wait (bounded) for in_ready before driving an accept edge.
  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk_bit({name, "_ready_seen"}, in_ready, 1'b1);
  endtask

  // One complete transaction with out_ready held high.
  task automatic do_mult(input string name, input int av, input int bv,
                         input int exp_prod, input int exp_lat);
    int lat;
    wait_ready(name);
    out_ready = 1'b1;
    a = W'(av);
    b = W'(bv);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = '0;
    b = '0;
    chk_bit({name, "_busy"}, busy, 1'b1);
    wait_done(lat);
    chk_int({name, "_latency"}, lat, exp_lat);
    chk_int({name, "_product"}, int'(product), exp_prod);
    tick();
    chk_bit({name, "_in_ready_after"}, in_ready, 1'b1);
    chk_bit({name, "_out_valid_after"}, out_valid, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_bit("reset_in_ready", in_ready, 1'b1);
    chk_bit("reset_out_valid", out_valid, 1'b0);
    chk_bit("reset_busy", busy, 1'b0);
    chk_int("reset_product", int'(product), 0);
  endtask

  task automatic test_basic();
    do_mult("mul_13x11", 13, 11, 143, pick_lat(8, 4));
    do_mult("mul_255x255", 255, 255, 65025, pick_lat(8, 8));
    do_mult("mul_0x200", 0, 200, 0, pick_lat(8, 8));
    do_mult("mul_1x128", 1, 128, 128, pick_lat(8, 8));
    do_mult("mul_9x0", 9, 0, 0, pick_lat(8, 1));
    do_mult("mul_200x1", 200, 1, 200, pick_lat(8, 1));
  endtask

  task automatic test_backpressure();
    int lat;
    wait_ready("bp");
    out_ready = 1'b0;
    a = 8'd13;
    b = 8'd11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    chk_int("bp_latency", lat, pick_lat(8, 4));
    for (int i = 0; i < 5; i++) begin
      // Offer a new pair mid-stall; it must be ignored.
      in_valid = (i == 1 || i == 2);
      a = 8'd5;
      b = 8'd5;
      tick();
      chk_bit("bp_out_valid_hold", out_valid, 1'b1);
      chk_int("bp_product_hold", int'(product), 143);
      chk_bit("bp_in_ready_low", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_bit("bp_released_out_valid", out_valid, 1'b0);
    chk_bit("bp_released_in_ready", in_ready, 1'b1);
    chk_bit("bp_released_busy", busy, 1'b0);
  endtask

  task automatic test_back_to_back();
    int av [3] = '{3, 7, 200};
    int bv [3] = '{4, 9, 100};
    int pv [3] = '{12, 63, 20000};
    int lv [3];
    int acc_cyc [3];
    int lat;
    lv = '{pick_lat(8, 3), pick_lat(8, 4), pick_lat(8, 7)};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = W'(av[i]);
      b = W'(bv[i]);
      wait_ready("b2b");
      tick();
      acc_cyc[i] = cyc;
      wait_done(lat);
      chk_int("b2b_latency", lat, lv[i]);
      chk_int("b2b_product", int'(product), pv[i]);
    end
    in_valid = 1'b0;
    tick();
    chk_bit("b2b_idle_after", in_ready, 1'b1);
    chk_int("b2b_period_01", acc_cyc[1] - acc_cyc[0], lv[0] + 2);
    chk_int("b2b_period_12", acc_cyc[2] - acc_cyc[1], lv[1] + 2);
  endtask

  task automatic test_reset_mid_run();
    wait_ready("rmr");
    out_ready = 1'b1;
    a = 8'd255;
    b = 8'd255;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_bit("rmr_busy", busy, 1'b0);
    chk_bit("rmr_out_valid", out_valid, 1'b0);
    chk_bit("rmr_in_ready", in_ready, 1'b1);
    chk_int("rmr_product", int'(product), 0);
    do_mult("rmr_6x7", 6, 7, 42, pick_lat(8, 3));
  endtask

  task automatic test_done_overlap();
    int lat;
    wait_ready("ovl");
    out_ready = 1'b0;
    a = 8'd3;
    b = 8'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    chk_int("ovl_first_product", int'(product), 15);
    // Consume and offer a new pair on the same DONE edge.
    a = 8'd2;
    b = 8'd9;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    chk_bit("ovl_not_accepted_busy", busy, 1'b0);
    chk_bit("ovl_consumed_out_valid", out_valid, 1'b0);
    chk_bit("ovl_idle_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_bit("ovl_accepted_busy", busy, 1'b1);
    chk_bit("ovl_accepted_in_ready", in_ready, 1'b0);
    wait_done(lat);
    chk_int("ovl_second_latency", lat, pick_lat(8, 4));
    chk_int("ovl_second_product", int'(product), 18);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_done_overlap();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
